// File: rtl/stage_three.sv
// ============================================================================
// Module      : stage_three
// Description : Memory-access / write-back stage of the 16-bit pipelined CPU.
//               Issues data-memory loads/stores over req/ack and drives s3_*.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_three #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt_sys,
   input  logic        in_valid,
   input  logic [1:0]  in_memc,
   input  logic        in_reg_wr,
   input  logic        in_R0_en,
   input  logic [31:0] in_alu,
   input  logic [15:0] in_R1_data,
   input  logic [15:0] in_instr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic        mem_stall,
   output logic        s3_reg_wr,
   output logic        s3_R0_en,
   output logic [15:0] s3_instruction,
   output logic [31:0] s3_data,
   output logic        mem_fault
);

   localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_req;
   logic        r_we;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_pend_instr;
   logic        r_pend_reg_wr;
   logic        r_s3_reg_wr;
   logic        r_s3_R0_en;
   logic [15:0] r_s3_instr;
   logic [31:0] r_s3_data;
   logic        r_fault;

   logic w_mem_op;
   logic w_timeout;

   // A combined mem2r+memwr encoding is treated as a write.
   assign w_mem_op  = in_valid & (|in_memc) & ~halt_sys;
   assign w_timeout = (r_cnt == c_TIMEOUT);

   assign mem_stall = ((r_state == S_IDLE) & w_mem_op) |
                      ((r_state == S_ACCESS) & ~dmem_ack & ~w_timeout);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 8'd0;
         r_req         <= 1'b0;
         r_we          <= 1'b0;
         r_addr        <= 16'h0000;
         r_wdata       <= 16'h0000;
         r_pend_instr  <= 16'h0000;
         r_pend_reg_wr <= 1'b0;
         r_s3_reg_wr   <= 1'b0;
         r_s3_R0_en    <= 1'b0;
         r_s3_instr    <= 16'h0000;
         r_s3_data     <= 32'h0000_0000;
         r_fault       <= 1'b0;
      end else begin
         // Enables default low: any edge without a completion is a bubble.
         r_s3_reg_wr <= 1'b0;
         r_s3_R0_en  <= 1'b0;
         if (r_state == S_IDLE) begin
            if (w_mem_op) begin
               r_addr        <= in_alu[15:0];
               r_wdata       <= in_R1_data;
               r_we          <= in_memc[0];
               r_pend_instr  <= in_instr;
               r_pend_reg_wr <= in_reg_wr;
               r_req         <= 1'b1;
               r_cnt         <= 8'd0;
               r_state       <= S_ACCESS;
            end else if (in_valid & ~halt_sys) begin
               r_s3_data   <= in_alu;
               r_s3_reg_wr <= in_reg_wr;
               r_s3_R0_en  <= in_R0_en;
               r_s3_instr  <= in_instr;
            end
         end else begin
            if (dmem_ack) begin
               r_req      <= 1'b0;
               r_state    <= S_IDLE;
               r_s3_instr <= r_pend_instr;
               if (r_we) begin
                  r_s3_data <= {16'h0000, r_addr};
               end else begin
                  r_s3_data   <= {16'h0000, dmem_rdata};
                  r_s3_reg_wr <= r_pend_reg_wr;
               end
            end else if (w_timeout) begin
               r_req   <= 1'b0;
               r_fault <= 1'b1;
               r_state <= S_IDLE;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign dmem_req       = r_req;
   assign dmem_we        = r_we;
   assign dmem_addr      = r_addr;
   assign dmem_wdata     = r_wdata;
   assign s3_reg_wr      = r_s3_reg_wr;
   assign s3_R0_en       = r_s3_R0_en;
   assign s3_instruction = r_s3_instr;
   assign s3_data        = r_s3_data;
   assign mem_fault      = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_stage_three.sv
// ============================================================================
// Module      : tb_stage_three
// Description : Self-checking bench for stage_three: directed cases plus a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_three;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        halt_sys;
   logic        in_valid;
   logic [1:0]  in_memc;
   logic        in_reg_wr;
   logic        in_R0_en;
   logic [31:0] in_alu;
   logic [15:0] in_R1_data;
   logic [15:0] in_instr;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;
   logic        mem_stall;
   logic        s3_reg_wr;
   logic        s3_R0_en;
   logic [15:0] s3_instruction;
   logic [31:0] s3_data;
   logic        mem_fault;

   always #5 clk = ~clk;

   stage_three #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid),
      .in_memc(in_memc), .in_reg_wr(in_reg_wr), .in_R0_en(in_R0_en),
      .in_alu(in_alu), .in_R1_data(in_R1_data), .in_instr(in_instr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .s3_reg_wr(s3_reg_wr), .s3_R0_en(s3_R0_en),
      .s3_instruction(s3_instruction), .s3_data(s3_data), .mem_fault(mem_fault)
   );

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding transaction with the number of cycles
   // its request has been visible; write-back results computed per rule.
   logic        m_busy = 1'b0;
   int          m_cyc = 0;
   logic        m_we = 1'b0;
   logic [15:0] m_addr = '0, m_wdata = '0, m_instr = '0;
   logic        m_rw = 1'b0;
   logic [31:0] e_data = '0;
   logic [15:0] e_instr = '0;
   logic        e_rw = 1'b0, e_r0 = 1'b0, e_fault = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_cyc = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_instr = 0; m_rw = 0;
         e_data = 0; e_instr = 0; e_rw = 0; e_r0 = 0; e_fault = 0;
      end else begin
         e_rw = 0;
         e_r0 = 0;
         if (!m_busy) begin
            if (in_valid && in_memc != 2'b00 && !halt_sys) begin
               m_busy = 1; m_cyc = 1; m_we = in_memc[0];
               m_addr = in_alu[15:0]; m_wdata = in_R1_data;
               m_instr = in_instr; m_rw = in_reg_wr;
            end else if (in_valid && !halt_sys) begin
               e_data = in_alu; e_rw = in_reg_wr; e_r0 = in_R0_en; e_instr = in_instr;
            end
         end else if (dmem_ack) begin
            m_busy = 0;
            e_instr = m_instr;
            e_data = m_we ? {16'h0000, m_addr} : {16'h0000, dmem_rdata};
            e_rw = m_we ? 1'b0 : m_rw;
         end else if (m_cyc == TO + 1) begin
            m_busy = 0;
            e_fault = 1;
         end else begin
            m_cyc++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dmem_req", dmem_req, m_busy);
         chk("dmem_we", dmem_we, m_we);
         chk("dmem_addr", dmem_addr, m_addr);
         chk("dmem_wdata", dmem_wdata, m_wdata);
         chk("s3_reg_wr", s3_reg_wr, e_rw);
         chk("s3_R0_en", s3_R0_en, e_r0);
         chk("s3_instruction", s3_instruction, e_instr);
         chk("s3_data", s3_data, e_data);
         chk("mem_fault", mem_fault, e_fault);
         chk("mem_stall", mem_stall,
             m_busy ? (!dmem_ack && m_cyc != TO + 1)
                    : (in_valid && in_memc != 2'b00 && !halt_sys));
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_in();
      in_valid = 0; in_memc = 2'b00; in_reg_wr = 0; in_R0_en = 0;
      in_alu = '0; in_R1_data = '0; in_instr = '0; halt_sys = 0;
   endtask

   task automatic present(input logic [1:0] memc, input logic [31:0] alu,
                          input logic [15:0] r1, input logic [15:0] instr,
                          input logic rw, input logic r0);
      in_valid = 1; in_memc = memc; in_alu = alu; in_R1_data = r1;
      in_instr = instr; in_reg_wr = rw; in_R0_en = r0;
   endtask

   task automatic do_reset();
      rst = 1; nxt(); nxt(); rst = 0;
   endtask

   int rq;
   int lat;

   initial begin
      rst = 1; idle_in(); dmem_ack = 0; dmem_rdata = '0;
      nxt(); nxt();
      mid();
      chk("reset s3_data", s3_data, 32'h0);
      chk("reset dmem_req", dmem_req, 1'b0);
      chk("reset mem_fault", mem_fault, 1'b0);
      chk_en = 1;
      nxt(); rst = 0;

      // ALU instruction: one-cycle latency, then bubble.
      present(2'b00, 32'h0003_0005, 16'h0, 16'h1111, 1, 1);
      nxt(); idle_in(); mid();
      chk("alu s3_data", s3_data, 32'h0003_0005);
      chk("alu s3_reg_wr", s3_reg_wr, 1'b1);
      chk("alu s3_R0_en", s3_R0_en, 1'b1);
      nxt(); mid();
      chk("alu bubble en", {s3_reg_wr, s3_R0_en}, 2'b00);

      // Load from 0x0040, ack in cycle 3.
      nxt(); present(2'b10, 32'h0000_0040, 16'h0, 16'hA040, 1, 0); mid();
      chk("ld stall c0", mem_stall, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         nxt();
         if (c == 3) begin dmem_ack = 1; dmem_rdata = 16'hBEEF; end
         mid();
         chk("ld req", dmem_req, 1'b1);
         chk("ld stall", mem_stall, (c < 3) ? 1'b1 : 1'b0);
      end
      nxt(); dmem_ack = 0; idle_in(); mid();
      chk("ld req c4", dmem_req, 1'b0);
      chk("ld s3_data", s3_data, 32'h0000_BEEF);
      chk("ld s3_reg_wr", s3_reg_wr, 1'b1);
      chk("ld s3_instruction", s3_instruction, 16'hA040);

      // Store 0x1234 to 0x0010, ack in cycle 1.
      nxt(); present(2'b01, 32'h0000_0010, 16'h1234, 16'hB010, 1, 1);
      nxt(); dmem_ack = 1; mid();
      chk("st we", dmem_we, 1'b1);
      chk("st wdata", dmem_wdata, 16'h1234);
      chk("st addr", dmem_addr, 16'h0010);
      nxt(); dmem_ack = 0; idle_in(); mid();
      chk("st s3_reg_wr", s3_reg_wr, 1'b0);
      chk("st s3_data", s3_data, 32'h0000_0010);

      // Timeout: no ack.
      nxt(); present(2'b10, 32'h0000_0020, 16'h0, 16'hC020, 1, 0);
      for (int c = 1; c <= 5; c++) begin
         nxt(); mid();
         chk("to req", dmem_req, 1'b1);
         chk("to stall", mem_stall, (c < 5) ? 1'b1 : 1'b0);
         chk("to fault early", mem_fault, 1'b0);
      end
      nxt(); idle_in(); mid();
      chk("to req c6", dmem_req, 1'b0);
      chk("to fault c6", mem_fault, 1'b1);
      chk("to no wb", s3_reg_wr, 1'b0);
      nxt(); mid();
      chk("to fault sticky", mem_fault, 1'b1);

      // Reset during an outstanding load, then a late ack.
      nxt(); present(2'b10, 32'h0000_0044, 16'h0, 16'hD044, 1, 0);
      nxt(); nxt(); rst = 1;
      nxt(); rst = 0; idle_in(); dmem_ack = 1; dmem_rdata = 16'h5A5A; mid();
      chk("rst req", dmem_req, 1'b0);
      chk("rst fault", mem_fault, 1'b0);
      chk("rst s3_data", s3_data, 32'h0);
      nxt(); dmem_ack = 0; mid();
      chk("rst late ack wr", s3_reg_wr, 1'b0);
      chk("rst late ack data", s3_data, 32'h0);

      // Load (k=1) followed immediately by an ALU instruction.
      nxt(); present(2'b10, 32'h0000_0050, 16'h0, 16'hE050, 1, 0);
      nxt(); dmem_ack = 1; dmem_rdata = 16'h5555;
      nxt(); dmem_ack = 0; present(2'b00, 32'h0000_7777, 16'h0, 16'hF000, 1, 0); mid();
      chk("ldalu ld data", s3_data, 32'h0000_5555);
      chk("ldalu ld wr", s3_reg_wr, 1'b1);
      nxt(); idle_in(); mid();
      chk("ldalu alu data", s3_data, 32'h0000_7777);
      chk("ldalu alu wr", s3_reg_wr, 1'b1);
      nxt(); mid();
      chk("ldalu no dup", s3_reg_wr, 1'b0);

      // Randomized run with an auto-responding memory.
      rq = 0; lat = 1;
      for (int c = 0; c < 4000; c++) begin
         nxt();
         rst        = ($urandom_range(0, 99) == 0);
         halt_sys   = ($urandom_range(0, 7) == 0);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_memc    = 2'($urandom);
         in_reg_wr  = 1'($urandom);
         in_R0_en   = 1'($urandom);
         in_alu     = $urandom;
         in_R1_data = 16'($urandom);
         in_instr   = 16'($urandom);
         dmem_rdata = 16'($urandom);
         if (dmem_req) begin
            rq++;
            if (rq == 1) lat = $urandom_range(1, TO + 3);
            dmem_ack = (rq == lat);
         end else begin
            rq = 0;
            dmem_ack = ($urandom_range(0, 7) == 0);
         end
      end
      nxt(); idle_in(); dmem_ack = 0; rst = 0;
      nxt(); mid();
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
